// File: rtl/instr_fetch_buffer_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid port, redirect input
// and the valid/ready instruction output toward the decoder.
interface instr_fetch_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests and
// buffers in-order responses; redirects flush the queue and drain stale replies.
module instr_fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                  clk,
    input logic                  reset,
    instr_fetch_buffer_if.master bus
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [CW:0] used;
    logic        credit, req, grant, rsp, push, pop;

    always_comb begin
        used   = {1'b0, occ_q} + {1'b0, out_q};
        credit = used < DEPTH_S;
        // Reset gates the request so it stays low while reset is held.
        req    = reset & (state_q == RUN) & credit & ~bus.redirect;
        grant  = req & bus.imem_gnt;
        rsp    = bus.imem_rvalid & (out_q != '0);
        push   = rsp & (state_q == RUN) & ~bus.redirect & (occ_q != DEPTH_C);
        pop    = (occ_q != '0) & bus.instr_ready & ~bus.redirect;

        out_d  = out_q + CW'(grant) - CW'(rsp);
        fpc_d  = fpc_q;
        rpc_d  = rpc_q;
        occ_d  = occ_q;
        rd_d   = rd_q;
        wr_d   = wr_q;

        if (bus.redirect) begin
            fpc_d = bus.redirect_pc & ~XLEN'(3);
            rpc_d = bus.redirect_pc & ~XLEN'(3);
            occ_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else begin
            if (grant) fpc_d = fpc_q + XLEN'(4);
            if (push) begin
                rpc_d = rpc_q + XLEN'(4);
                wr_d  = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            occ_d = occ_q + CW'(push) - CW'(pop);
        end

        // Every response still owed at a redirect belongs to the old stream.
        if (bus.redirect) begin
            drop_d = out_d;
        end else if (state_q == DRAIN) begin
            drop_d = drop_q - CW'(rsp);
        end else begin
            drop_d = '0;
        end
        state_d = (drop_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
            occ_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            occ_q   <= occ_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if (push) begin
                instr_mem_q[wr_q] <= bus.imem_rdata;
                pc_mem_q[wr_q]    <= rpc_q;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fpc_q;
    assign bus.instr_valid = occ_q != '0;
    assign bus.instr       = instr_mem_q[rd_q];
    assign bus.pc          = pc_mem_q[rd_q];
    assign bus.pc_plus4    = pc_mem_q[rd_q] + XLEN'(4);
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomized bench for instr_fetch_buffer: behavioural memory with in-order
// replies, expected-stream scoreboard, and request-rule checks.
module tb_instr_fetch_buffer;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.XLEN(32)) bus ();

    instr_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_exp;
    int stale, occ_m, cyc, grants, first_g, first_v, acc, acc_since;
    int p_gnt, p_rv, p_rdy, p_redir;
    bit force_redir, redir_on_valid;
    logic [31:0] tgt;
    bit c_req, c_gnt, c_grant, c_rvalid, c_redir, c_pop, p_wait;
    logic [31:0] c_addr, p_addr;
    bit hold_prev;
    logic [31:0] h_instr, h_pc;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0013;
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(3))
            0:       return $urandom();
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       return 32'($urandom_range(255));
            default: return $urandom() & 32'h0000_0FFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Scoreboard monitor: every accepted instruction must be the next address
    // of the current stream, carrying that address's memory word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_instr", bus.instr, h_instr);
                chk("hold_pc", bus.pc, h_pc);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc 0x%08h expected no output", bus.pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.pc, e);
                    chk("sb_instr", bus.instr, memw(e));
                    chk("sb_pc4", bus.pc_plus4, e + 32'd4);
                    acc++;
                    acc_since++;
                end
            end
            hold_prev = bus.instr_valid && !bus.instr_ready && !bus.redirect;
            h_instr   = bus.instr;
            h_pc      = bus.pc;
        end
    end

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp);
            next_exp += 32'd4;
        end
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_req", bus.imem_req, 0);
            chk("rst_valid", bus.instr_valid, 0);
            chk("rst_instr", bus.instr, 0);
            chk("rst_pc", bus.pc, 0);
        end
        pend.delete();
        exp_q.delete();
        next_exp = RESET_PC;
        refill();
        stale = 0; occ_m = 0; grants = 0; first_g = -1; first_v = -1; acc_since = 0;
        {c_req, c_gnt, c_grant, c_rvalid, c_redir, c_pop} = '0;
        c_addr = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic step();
        logic [31:0] t;
        bit rd;
        @(posedge clk);
        cyc++;
        p_wait = c_req && !c_gnt && !c_redir;
        p_addr = c_addr;
        if (c_rvalid) begin
            t = pend.pop_front();
            if (!c_redir) begin
                if (stale > 0) stale--;
                else occ_m++;
            end
        end
        if (c_pop) occ_m--;
        if (c_grant) begin
            pend.push_back(c_addr);
            grants++;
        end
        if (c_redir) begin
            stale = pend.size();
            occ_m = 0;
        end
        #1;
        bus.imem_rvalid = (pend.size() != 0) && ($urandom_range(99) < p_rv);
        bus.imem_rdata  = bus.imem_rvalid ? memw(pend[0]) : $urandom();
        bus.imem_gnt    = $urandom_range(99) < p_gnt;
        bus.instr_ready = $urandom_range(99) < p_rdy;
        rd = force_redir || (redir_on_valid && bus.instr_valid) || ($urandom_range(999) < p_redir);
        bus.redirect = rd;
        if (rd) begin
            bus.redirect_pc = (force_redir || redir_on_valid) ? tgt : rand_target();
            force_redir = 1'b0;
            redir_on_valid = 1'b0;
            exp_q.delete();
            next_exp = bus.redirect_pc & ~32'd3;
            acc_since = 0;
        end else begin
            bus.redirect_pc = $urandom();
        end
        refill();
        #1;
        c_req    = bus.imem_req;
        c_gnt    = bus.imem_gnt;
        c_grant  = c_req && c_gnt;
        c_addr   = bus.imem_addr;
        c_rvalid = bus.imem_rvalid;
        c_redir  = rd;
        c_pop    = bus.instr_valid && bus.instr_ready && !rd;
        chk("req_rule", c_req, (stale == 0) && !rd && (pend.size() + occ_m < DEPTH));
        if (c_req) chk("addr_align", c_addr[1:0], 0);
        if (p_wait && c_req && !rd) chk("addr_stable", c_addr, p_addr);
        if (c_grant && first_g < 0) first_g = cyc;
        if (bus.instr_valid && first_v < 0) first_v = cyc;
    endtask

    task automatic knobs(input int g, input int r, input int y, input int d);
        p_gnt = g; p_rv = r; p_rdy = y; p_redir = d;
    endtask

    initial begin
        cyc = 0; acc = 0; hold_prev = 1'b0;
        force_redir = 1'b0; redir_on_valid = 1'b0; tgt = '0;
        knobs(100, 100, 0, 0);
        do_reset(1'b1);

        // Stall the consumer: only DEPTH words may be fetched, head holds pc 0.
        repeat (10) step();
        chk("stall_grants", grants, DEPTH);
        chk("stall_req", bus.imem_req, 0);
        chk("stall_valid", bus.instr_valid, 1);
        chk("stall_pc", bus.pc, 32'h0);
        chk("stall_instr", bus.instr, memw(32'h0));
        chk("latency", first_v - first_g, 2);
        knobs(100, 100, 100, 0);
        repeat (12) step();

        // Redirect with two requests in flight and replies held back.
        knobs(100, 0, 100, 0);
        repeat (4) step();
        tgt = 32'h100; force_redir = 1'b1;
        step();
        knobs(100, 100, 100, 0);
        repeat (12) step();
        chk("drain_progress", acc_since > 0, 1);

        // Redirect to a misaligned target while the head is being popped.
        tgt = 32'h102; redir_on_valid = 1'b1;
        repeat (3) step();
        repeat (12) step();
        chk("misalign_progress", acc_since > 0, 1);

        // Withheld grants near the top of the address space, then wrap.
        knobs(0, 100, 100, 0);
        tgt = 32'hFFFF_FFF4; force_redir = 1'b1;
        step();
        repeat (3) step();
        knobs(100, 100, 100, 0);
        repeat (14) step();
        chk("wrap_progress", acc_since >= 4, 1);

        // Reset with one request outstanding.
        knobs(0, 100, 100, 0);
        repeat (6) step();
        knobs(100, 0, 100, 0);
        step();
        knobs(0, 0, 100, 0);
        step();
        do_reset(1'b1);
        knobs(100, 100, 100, 0);
        repeat (10) step();
        chk("post_reset_progress", acc_since > 0, 1);

        // Randomized traffic with occasional redirects.
        for (int unsigned blk = 0; blk < 40; blk++) begin
            knobs($urandom_range(100, 30), $urandom_range(100, 30),
                  $urandom_range(100, 20), $urandom_range(30));
            repeat (50) step();
        end
        knobs(100, 100, 100, 0);
        repeat (20) step();
        chk("total_progress", acc > 200, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
